// File: rtl/camo_keyed_array.sv
// camo_keyed_array
//   Bank of N_CELLS keyed 2-input cells (NAND / NOR / XOR) whose functions
//   are set by a serially loaded key, followed by a registered datapath of
//   PIPE_STAGES (1 or 2) output registers. Data is only evaluated once a
//   complete key has been accepted.
//
//   Optional feature macro: CAMO_KEY_PARITY_EN
//     When defined, one extra parity bit follows the key and must equal the
//     XOR of all key bits; otherwise the block parks in ERR with key_err=1.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   key_start          one-cycle pulse: (re)start a key load, flush datapath
//   key_valid/key_bit  serial key bit, accepted when key_ready is high
//   key_ready          loader is accepting a bit this cycle
//   in_valid/in_a/in_b operands, one bit per cell, used only while armed
//   out_valid/out_y    result, PIPE_STAGES cycles after in_valid
//   armed              full key loaded, datapath live
//   key_err            last load failed its parity check (0 without parity)
module camo_keyed_array #(
    parameter int N_CELLS     = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_start,
    input  logic               key_valid,
    input  logic               key_bit,
    output logic               key_ready,
    input  logic               in_valid,
    input  logic [N_CELLS-1:0] in_a,
    input  logic [N_CELLS-1:0] in_b,
    output logic               out_valid,
    output logic [N_CELLS-1:0] out_y,
    output logic               armed,
    output logic               key_err
);

    localparam int KEY_W = 2 * N_CELLS;
    localparam int CW    = $clog2(KEY_W);
    localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef CAMO_KEY_PARITY_EN
        CHECK,
        ERR,
`endif
        ARMED
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              accept;

    assign accept = key_valid & key_ready;

    // ---------------- key loader FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        if (key_start) begin
            // restart wins over a bit offered in the same cycle
            state_d = LOAD;
            cnt_d   = '0;
            key_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        key_d[cnt_q] = key_bit;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
`ifdef CAMO_KEY_PARITY_EN
                            state_d = CHECK;
`else
                            state_d = ARMED;
`endif
                        end
                    end
                end
`ifdef CAMO_KEY_PARITY_EN
                CHECK: begin
                    // key_q is complete here, so its reduction is the parity
                    if (accept) state_d = (key_bit == ^key_q) ? ARMED : ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    // Pure decodes of the state register; no input feeds these outputs.
`ifdef CAMO_KEY_PARITY_EN
    assign key_ready = (state_q == LOAD) || (state_q == CHECK);
    assign key_err   = (state_q == ERR);
`else
    assign key_ready = (state_q == LOAD);
    assign key_err   = 1'b0;
`endif
    assign armed = (state_q == ARMED);

    // ---------------- keyed cells ----------------
    logic [N_CELLS-1:0] cell_y;

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        // s0 selects XOR outright; otherwise s1 picks NOR over NAND
        assign cell_y[i] = key_q[2*i]   ? (in_a[i] ^ in_b[i])    :
                           key_q[2*i+1] ? ~(in_a[i] | in_b[i]) :
                                          ~(in_a[i] & in_b[i]);
    end

    // ---------------- output pipeline ----------------
    logic                              fire;
    logic [PIPE_STAGES-1:0]            vld_q;
    logic [PIPE_STAGES-1:0][N_CELLS-1:0] data_q;

    assign fire = in_valid & armed;

    // Data registers only load on a valid beat so out_y holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else if (key_start) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= fire;
            if (fire) data_q[0] <= cell_y;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) data_q[s] <= data_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_y     = data_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_camo_keyed_array.sv
module tb_camo_keyed_array;

    localparam int N = 4;
    localparam int P = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_start, key_valid, key_bit, key_ready;
    logic         in_valid, out_valid, armed, key_err;
    logic [N-1:0] in_a, in_b, out_y;

    int n_chk  = 0;
    int n_fail = 0;

    camo_keyed_array #(.N_CELLS(N), .PIPE_STAGES(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start(key_start), .key_valid(key_valid), .key_bit(key_bit),
        .key_ready(key_ready),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_y(out_y),
        .armed(armed), .key_err(key_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] k, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            tick();
        end
        key_valid = 1'b0;
    endtask

    // Appends a correct parity bit when the parity feature is built in.
    task automatic finish_key(input logic [7:0] k);
`ifdef CAMO_KEY_PARITY_EN
        key_valid = 1'b1;
        key_bit   = ^k;
        tick();
        key_valid = 1'b0;
`else
        if (k == 8'hxx) $display("unreachable");
`endif
    endtask

    task automatic load_key(input logic [7:0] k);
        pulse_start();
        send_bits(k, 0, 7);
        finish_key(k);
    endtask

    initial begin
        // Key bit k goes to key[k]; cell i uses {s1,s0} = key[2i+1:2i].
        // 00 NAND: ~(1100 & 1010) = ~1000 = 0111
        vecs[0] = '{8'h00, 4'b1100, 4'b1010, 4'b0111};
        // cell0 XOR, cell1 NOR, cell2 NAND, cell3 XOR -> key 1100_1001
        // a=0110 b=0101: c0 0^1=1, c1 ~(1|0)=0, c2 ~(1&1)=0, c3 0^0=0
        vecs[1] = '{8'hC9, 4'b0110, 4'b0101, 4'b0001};
        // all NOR (s1=1,s0=0): ~(1100 | 1010) = 0001
        vecs[2] = '{8'hAA, 4'b1100, 4'b1010, 4'b0001};
        // all NAND with both operands high -> 0
        vecs[3] = '{8'h00, 4'hF, 4'hF, 4'h0};
        // all XOR: A ^ 3 = 9
        vecs[4] = '{8'hFF, 4'hA, 4'h3, 4'h9};

        rst_n = 1'b0; key_start = 0; key_valid = 0; key_bit = 0;
        in_valid = 0; in_a = '0; in_b = '0;
        tick(); tick();
        chk("rst_key_ready", key_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_armed", armed, 0);
        chk("rst_key_err", key_err, 0);
        rst_n = 1'b1;

        // unarmed datapath ignores in_valid
        in_valid = 1; in_a = 4'hF; in_b = 4'hF;
        tick(); tick();
        chk("unarmed_out_valid", out_valid, 0);
        chk("unarmed_out_y", out_y, 0);
        chk("unarmed_armed", armed, 0);
        in_valid = 0;

        // armed timing: rises only the cycle after the final bit
        pulse_start();
        chk("start_key_ready", key_ready, 1);
        send_bits(8'h00, 0, 6);
        chk("seven_bits_armed", armed, 0);
        chk("seven_bits_ready", key_ready, 1);
        send_bits(8'h00, 7, 7);
        finish_key(8'h00);
        chk("full_key_armed", armed, 1);
        chk("full_key_ready", key_ready, 0);

        // table-driven function checks
        for (int v = 0; v < 5; v++) begin
            load_key(vecs[v].key);
            chk($sformatf("v%0d_armed", v), armed, 1);
            in_valid = 1; in_a = vecs[v].a; in_b = vecs[v].b;
            tick();
            in_valid = 0;
            chk($sformatf("v%0d_out_valid", v), out_valid, 1);
            chk($sformatf("v%0d_out_y", v), out_y, vecs[v].y);
            in_a = ~vecs[v].a;
            tick();
            chk($sformatf("v%0d_idle_valid", v), out_valid, 0);
            chk($sformatf("v%0d_hold_y", v), out_y, vecs[v].y);
        end

        // restart after 3 bits; the bit offered alongside key_start is dropped
        pulse_start();
        send_bits(8'h00, 0, 2);
        key_start = 1; key_valid = 1; key_bit = 0;
        tick();
        key_start = 0; key_valid = 0;
        chk("restart_ready", key_ready, 1);
        chk("restart_flush_y", out_y, 0);
        send_bits(8'hFF, 0, 6);
        chk("restart_7_armed", armed, 0);
        send_bits(8'hFF, 7, 7);
        finish_key(8'hFF);
        chk("restart_armed", armed, 1);
        in_valid = 1; in_a = 4'hA; in_b = 4'h3;
        tick();
        in_valid = 0;
        chk("restart_xor_y", out_y, 4'h9);

        // back-to-back with key_start on beat 3 (XOR key, b=0 so y=a)
        for (int c = 1; c <= 5; c++) begin
            in_valid = 1; in_a = 4'(c); in_b = 4'h0;
            key_start = (c == 3);
            tick();
            key_start = 0;
            chk($sformatf("flush_c%0d_valid", c), out_valid, (c < 3) ? 1 : 0);
            chk($sformatf("flush_c%0d_y", c), out_y, (c < 3) ? c : 0);
        end
        in_valid = 0;
        chk("flush_armed", armed, 0);

`ifdef CAMO_KEY_PARITY_EN
        pulse_start();
        send_bits(8'h01, 0, 7);
        key_valid = 1; key_bit = 0;
        tick();
        key_valid = 0;
        chk("par_bad_err", key_err, 1);
        chk("par_bad_armed", armed, 0);
        in_valid = 1; in_a = 4'h5; in_b = 4'h0;
        tick();
        in_valid = 0;
        chk("par_bad_no_out", out_valid, 0);
        pulse_start();
        chk("par_restart_err", key_err, 0);
        send_bits(8'h01, 0, 7);
        key_valid = 1; key_bit = 1;
        tick();
        key_valid = 0;
        chk("par_good_armed", armed, 1);
        chk("par_good_err", key_err, 0);
`else
        chk("nopar_key_err", key_err, 0);
`endif

        // asynchronous reset mid-pipeline
        load_key(8'hFF);
        in_valid = 1; in_a = 4'h5; in_b = 4'h0;
        tick();
        chk("pre_rst_y", out_y, 4'h5);
        in_a = 4'h6;
        #3 rst_n = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_y", out_y, 0);
        chk("async_rst_armed", armed, 0);
        tick();
        chk("held_rst_y", out_y, 0);
        chk("held_rst_ready", key_ready, 0);
        in_valid = 0;
        rst_n = 1;
        tick();
        chk("post_rst_armed", armed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
